// File: rtl/share_packer.sv
// Purpose: gathers N_SHARES share words and RANDNUM random words into one packed transaction for XOR unmasking.
// Latency: o_dvld pulses in the cycle right after the edge that accepts the final word (ena high).
// Backpressure: s_rdy/r_rdy drop once a lane is full, while issuing, during rst, or with ena low.
module share_packer #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    parameter int RANDNUM  = (N_SHARES == 1) ? 0 :
        ($clog2(N_SHARES + 1) - 1) *
        (1 << (($clog2(N_SHARES + 1) >= 2) ? ($clog2(N_SHARES + 1) - 2) : 0)) +
        N_SHARES - (1 << ($clog2(N_SHARES + 1) - 1))
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           ena,
    input  logic                                           s_vld,
    output logic                                           s_rdy,
    input  logic [K_WIDTH-1:0]                             s_data,
    input  logic                                           r_vld,
    output logic                                           r_rdy,
    input  logic [K_WIDTH-1:0]                             r_data,
    output logic [K_WIDTH*N_SHARES-1:0]                    o_x,
    output logic [K_WIDTH*((RANDNUM > 0) ? RANDNUM : 1)-1:0] o_rnd,
    output logic                                           o_dvld
);

    // A zero-randomness build still keeps one (always-zero) random slot so widths stay legal.
    localparam int RND_SLOTS = (RANDNUM > 0) ? RANDNUM : 1;
    localparam int SH_W      = $clog2(N_SHARES + 1);
    localparam int RN_W      = (RANDNUM > 0) ? $clog2(RANDNUM + 1) : 1;
    localparam logic [SH_W-1:0] SH_FULL = SH_W'(N_SHARES);
    localparam logic [RN_W-1:0] RN_FULL = RN_W'(RANDNUM);

    typedef enum logic {COLLECT, ISSUE} state_t;

    state_t                  state;
    logic [SH_W-1:0]         sh_cnt;
    logic [SH_W-1:0]         sh_nxt;
    logic [RN_W-1:0]         rn_cnt;
    logic [RN_W-1:0]         rn_nxt;
    logic [K_WIDTH-1:0]      sh_buf  [N_SHARES];
    logic [K_WIDTH-1:0]      rn_buf  [RND_SLOTS];
    logic [K_WIDTH-1:0]      sh_view [N_SHARES];
    logic [K_WIDTH-1:0]      rn_view [RND_SLOTS];
    logic [K_WIDTH*N_SHARES-1:0]  x_pack;
    logic [K_WIDTH*RND_SLOTS-1:0] r_pack;
    logic                    s_acc;
    logic                    r_acc;
    logic                    done;

    assign s_rdy = !rst && ena && (state == COLLECT) && (sh_cnt < SH_FULL);

    if (RANDNUM > 0) begin : g_rnd
        assign r_rdy = !rst && ena && (state == COLLECT) && (rn_cnt < RN_FULL);
    end else begin : g_no_rnd
        assign r_rdy = 1'b0;
    end

    // The pulse lives in the ISSUE cycle itself; ena low defers it, nothing downstream can.
    assign o_dvld = !rst && ena && (state == ISSUE);

    assign s_acc = s_vld && s_rdy;
    assign r_acc = r_vld && r_rdy;

    // Per-slot "buffer after this cycle" view, so the output load includes the word landing on the same edge.
    always_comb begin
        sh_nxt = sh_cnt + SH_W'(s_acc);
        rn_nxt = rn_cnt + RN_W'(r_acc);
        done   = (sh_nxt == SH_FULL) && (rn_nxt == RN_FULL);
        x_pack = '0;
        r_pack = '0;
        for (int i = 0; i < N_SHARES; i++) begin
            sh_view[i] = (s_acc && (sh_cnt == SH_W'(i))) ? s_data : sh_buf[i];
            x_pack[i*K_WIDTH +: K_WIDTH] = sh_view[i];
        end
        for (int j = 0; j < RND_SLOTS; j++) begin
            rn_view[j] = (r_acc && (rn_cnt == RN_W'(j))) ? r_data : rn_buf[j];
            r_pack[j*K_WIDTH +: K_WIDTH] = rn_view[j];
        end
    end

    // Collect/issue sequencing, buffer writes and output register load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            sh_cnt <= '0;
            rn_cnt <= '0;
            o_x    <= '0;
            o_rnd  <= '0;
            for (int i = 0; i < N_SHARES; i++) sh_buf[i] <= '0;
            for (int j = 0; j < RND_SLOTS; j++) rn_buf[j] <= '0;
        end else if (ena) begin
            if (state == COLLECT) begin
                sh_cnt <= sh_nxt;
                rn_cnt <= rn_nxt;
                for (int i = 0; i < N_SHARES; i++) sh_buf[i] <= sh_view[i];
                for (int j = 0; j < RND_SLOTS; j++) rn_buf[j] <= rn_view[j];
                if (done) begin
                    state <= ISSUE;
                    o_x   <= x_pack;
                    o_rnd <= r_pack;
                end
            end else begin
                sh_cnt <= '0;
                rn_cnt <= '0;
                state  <= COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_share_packer.sv
// Purpose: directed bench for share_packer (default build plus an N_SHARES=1 build) against a queue-based model.
// Latency: inputs change 1ns after the rising edge; the model is checked on every falling edge.
// Backpressure: sources hold words until the model says they were taken.
`timescale 1ns/1ps
module tb_share_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena;
    logic        s_vld, r_vld;
    logic [31:0] s_data, r_data;
    logic        s_rdy, r_rdy, o_dvld;
    logic [95:0] o_x;
    logic [63:0] o_rnd;

    logic        s1_vld, r1_vld;
    logic [31:0] s1_data, r1_data;
    logic        s1_rdy, r1_rdy, o1_dvld;
    logic [31:0] o1_x, o1_rnd;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    share_packer u_dut (
        .clk(clk), .rst(rst), .ena(ena),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
        .r_vld(r_vld), .r_rdy(r_rdy), .r_data(r_data),
        .o_x(o_x), .o_rnd(o_rnd), .o_dvld(o_dvld)
    );

    share_packer #(.K_WIDTH(32), .N_SHARES(1)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena),
        .s_vld(s1_vld), .s_rdy(s1_rdy), .s_data(s1_data),
        .r_vld(r1_vld), .r_rdy(r1_rdy), .r_data(r1_data),
        .o_x(o1_x), .o_rnd(o1_rnd), .o_dvld(o1_dvld)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a transaction is just the list of words taken so far; it issues once both lists are full.
    logic [31:0] m_sh[$];
    logic [31:0] m_rn[$];
    bit          m_issue = 1'b0;
    logic [95:0] m_ox    = '0;
    logic [63:0] m_ornd  = '0;
    bit          m_sacc  = 1'b0;
    bit          chk_on  = 1'b0;

    function automatic bit exp_srdy();
        return !rst && ena && !m_issue && (m_sh.size() < 3);
    endfunction

    function automatic bit exp_rrdy();
        return !rst && ena && !m_issue && (m_rn.size() < 2);
    endfunction

    always @(posedge clk) begin : model_upd
        bit sa, ra;
        sa = s_vld && exp_srdy();
        ra = r_vld && exp_rrdy();
        m_sacc = 1'b0;
        if (rst) begin
            m_sh.delete();
            m_rn.delete();
            m_issue = 1'b0;
            m_ox    = '0;
            m_ornd  = '0;
        end else if (ena) begin
            if (m_issue) begin
                m_sh.delete();
                m_rn.delete();
                m_issue = 1'b0;
            end else begin
                if (sa) begin
                    m_sh.push_back(s_data);
                    m_sacc = 1'b1;
                end
                if (ra) m_rn.push_back(r_data);
                if (m_sh.size() == 3 && m_rn.size() == 2) begin
                    m_issue = 1'b1;
                    for (int i = 0; i < 3; i++) m_ox[i*32 +: 32] = m_sh[i];
                    for (int j = 0; j < 2; j++) m_ornd[j*32 +: 32] = m_rn[j];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp s_rdy", s_rdy, exp_srdy());
            chk("cmp r_rdy", r_rdy, exp_rrdy());
            chk("cmp o_dvld", o_dvld, !rst && ena && m_issue);
            chk("cmp o_x", o_x, m_ox);
            chk("cmp o_rnd", o_rnd, m_ornd);
        end
    end

    initial begin
        int pulses, last, first;
        ena = 1'b1; s_vld = 1'b0; r_vld = 1'b0; s_data = '0; r_data = '0;
        s1_vld = 1'b0; r1_vld = 1'b0; s1_data = '0; r1_data = '0;

        // Reset state
        tick();
        chk_on = 1'b1;
        chk("rst o_dvld", o_dvld, 0);
        chk("rst o_x", o_x, 0);
        chk("rst o_rnd", o_rnd, 0);
        chk("rst s_rdy", s_rdy, 0);
        chk("rst r_rdy", r_rdy, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle s_rdy", s_rdy, 1);
        chk("idle r_rdy", r_rdy, 1);

        // Basic transaction, one word per cycle
        s_vld = 1'b1; s_data = 32'h11111111; r_vld = 1'b1; r_data = 32'hA5A5A5A5; tick();
        s_data = 32'h22222222; r_data = 32'h5A5A5A5A; tick();
        s_data = 32'h44444444; r_vld = 1'b0; tick();
        s_vld = 1'b0;
        chk("t1 dvld", o_dvld, 1);
        chk("t1 o_x", o_x, 96'h44444444_22222222_11111111);
        chk("t1 o_rnd", o_rnd, 64'h5A5A5A5A_A5A5A5A5);
        tick();
        chk("t1 dvld drop", o_dvld, 0);
        chk("t1 o_x hold", o_x, 96'h44444444_22222222_11111111);

        // Late randomness; an extra share is offered but must not be taken
        s_vld = 1'b1; s_data = 32'h01020304; tick();
        s_data = 32'h05060708; tick();
        s_data = 32'h090A0B0C; tick();
        chk("t2 s_rdy full", s_rdy, 0);
        s_data = 32'h99999999;
        repeat (2) begin
            tick();
            chk("t2 wait dvld", o_dvld, 0);
            chk("t2 wait o_x", o_x, 96'h44444444_22222222_11111111);
        end
        r_vld = 1'b1; r_data = 32'hDEADBEEF; tick();
        chk("t2 one rnd dvld", o_dvld, 0);
        r_data = 32'hCAFEF00D; tick();
        r_vld = 1'b0; s_vld = 1'b0;
        chk("t2 dvld", o_dvld, 1);
        chk("t2 o_x", o_x, 96'h090A0B0C_05060708_01020304);
        chk("t2 o_rnd", o_rnd, 64'hCAFEF00D_DEADBEEF);
        tick();
        chk("t2 dvld drop", o_dvld, 0);

        // ena low while issuing holds the pulse back
        s_vld = 1'b1; r_vld = 1'b1; s_data = 32'hAAAA0000; r_data = 32'h00001111; tick();
        s_data = 32'hAAAA0001; r_data = 32'h00002222; tick();
        s_data = 32'hAAAA0002; tick();
        ena = 1'b0; s_data = 32'hBBBBBBBB; r_data = 32'h33333333;
        repeat (4) begin
            #1;
            chk("t3 ena-low dvld", o_dvld, 0);
            chk("t3 ena-low s_rdy", s_rdy, 0);
            tick();
        end
        ena = 1'b1; s_vld = 1'b0; r_vld = 1'b0;
        #1;
        chk("t3 dvld", o_dvld, 1);
        chk("t3 o_x", o_x, 96'hAAAA0002_AAAA0001_AAAA0000);
        chk("t3 o_rnd", o_rnd, 64'h00002222_00001111);
        tick();
        chk("t3 dvld drop", o_dvld, 0);

        // Reset in the middle of a transaction
        s_vld = 1'b1; r_vld = 1'b1; s_data = 32'hC0C0C0C0; r_data = 32'hD0D0D0D0; tick();
        s_data = 32'hC1C1C1C1; r_vld = 1'b0; tick();
        rst = 1'b1; s_data = 32'hE0E0E0E0; tick();
        chk("t4 rst o_x", o_x, 0);
        chk("t4 rst o_rnd", o_rnd, 0);
        chk("t4 rst s_rdy", s_rdy, 0);
        chk("t4 rst r_rdy", r_rdy, 0);
        rst = 1'b0; r_vld = 1'b1; r_data = 32'hF0F0F0F0; tick();
        s_data = 32'hE1E1E1E1; r_data = 32'hF1F1F1F1; tick();
        s_data = 32'hE2E2E2E2; r_vld = 1'b0; tick();
        s_vld = 1'b0;
        chk("t4 dvld", o_dvld, 1);
        chk("t4 o_x", o_x, 96'hE2E2E2E2_E1E1E1E1_E0E0E0E0);
        chk("t4 o_rnd", o_rnd, 64'hF1F1F1F1_F0F0F0F0);
        tick();

        // Back-to-back with valids always high
        s_vld = 1'b1; r_vld = 1'b1; s_data = 32'h50000000; r_data = 32'h60000000;
        pulses = 0; last = -1; first = -1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (m_sacc) s_data = s_data + 32'd1;
            r_data = r_data + 32'd1;
            #1;
            if (o_dvld) begin
                if (last >= 0) chk("t5 gap", c - last, 4);
                else first = c;
                pulses++;
                last = c;
            end
        end
        s_vld = 1'b0; r_vld = 1'b0;
        chk("t5 first pulse", first, 3);
        chk("t5 pulses", pulses, 4);
        tick();

        // N_SHARES = 1 build
        r1_vld = 1'b1; r1_data = 32'h77777777;
        #1;
        chk("n1 r_rdy", r1_rdy, 0);
        s1_vld = 1'b1; s1_data = 32'h0DD00001; tick();
        s1_data = 32'h0DD00002;
        chk("n1 dvld a", o1_dvld, 1);
        chk("n1 o_x a", o1_x, 32'h0DD00001);
        chk("n1 o_rnd", o1_rnd, 0);
        tick();
        chk("n1 dvld gap", o1_dvld, 0);
        chk("n1 s_rdy", s1_rdy, 1);
        chk("n1 r_rdy busy", r1_rdy, 0);
        tick();
        s1_vld = 1'b0;
        chk("n1 dvld b", o1_dvld, 1);
        chk("n1 o_x b", o1_x, 32'h0DD00002);
        tick();
        chk("n1 dvld end", o1_dvld, 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
